// File: rtl/lfsr_gen_if.sv
// Handshake/bus bundle for lfsr_gen: step/load controls in, state and monitor flags out.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] data;
    logic             serial_out;
    logic             lockup;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] step_cnt;

    modport master (
        output en, load, load_value,
        input  data, serial_out, lockup, wrap, period, step_cnt
    );

    modport slave (
        input  en, load, load_value,
        output data, serial_out, lockup, wrap, period, step_cnt
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with parallel load, all-zero recovery,
// serial tap and a SEED-to-SEED period monitor.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h8A),
    parameter int unsigned      MODE  = 0
) (
    input logic        clk,
    input logic        reset,
    lfsr_gen_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q,   wrap_d;
    logic [WIDTH-1:0] step_c;

    // One-step successor of the current state for the selected structure.
    generate
        if (MODE == 0) begin : g_fib
            logic fb_c;
            always_comb begin
                fb_c   = ^(data_q & TAPS);
                step_c = {data_q[WIDTH-2:0], fb_c};
            end
        end else begin : g_gal
            always_comb begin
                step_c = {data_q[WIDTH-2:0], 1'b0} ^ (data_q[WIDTH-1] ? TAPS : ZERO);
            end
        end
    endgenerate

    // Next-state: load beats lock-up recovery, which beats a normal step.
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (bus.load) begin
            data_d = bus.load_value;
            cnt_d  = ZERO;
        end else if (bus.en && (data_q == ZERO)) begin
            data_d   = SEED;
            lockup_d = 1'b1;
            cnt_d    = ZERO;
        end else if (bus.en) begin
            data_d = step_c;
            if (step_c == SEED) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + ONE;
                cnt_d    = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= SEED;
            cnt_q    <= ZERO;
            period_q <= ZERO;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.serial_out = data_q[WIDTH-1];
    assign bus.lockup     = lockup_q;
    assign bus.wrap       = wrap_q;
    assign bus.period     = period_q;
    assign bus.step_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci and Galois instances, hand-computed vectors.
module tb_lfsr_gen;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    lfsr_gen_if #(.WIDTH(8)) fib_if ();
    lfsr_gen_if #(.WIDTH(8)) gal_if ();

    lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h8A), .MODE(0)) u_fib (
        .clk   (clk),
        .reset (reset),
        .bus   (fib_if)
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h8A), .MODE(1)) u_gal (
        .clk   (clk),
        .reset (reset),
        .bus   (gal_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fib(input string tag, input logic [7:0] d, input logic [7:0] cnt,
                             input logic [7:0] per, input logic lk, input logic wr);
        check({tag, ".data"},     32'(fib_if.data),     32'(d));
        check({tag, ".step_cnt"}, 32'(fib_if.step_cnt), 32'(cnt));
        check({tag, ".period"},   32'(fib_if.period),   32'(per));
        check({tag, ".lockup"},   32'(fib_if.lockup),   32'(lk));
        check({tag, ".wrap"},     32'(fib_if.wrap),     32'(wr));
        check({tag, ".serial"},   32'(fib_if.serial_out), 32'(d[7]));
    endtask

    logic [7:0] fib_exp [3];
    logic [7:0] gal_exp [3];
    logic       seen [256];
    int         nwrap;
    int         nrepeat;

    initial begin
        total = 0;
        bad   = 0;
        fib_exp = '{8'h14, 8'h29, 8'h52};
        gal_exp = '{8'h09, 8'h12, 8'h24};
        fib_if.en = 1'b0; fib_if.load = 1'b0; fib_if.load_value = 8'h00;
        gal_if.en = 1'b0; gal_if.load = 1'b0; gal_if.load_value = 8'h00;

        // Reset asserted before any clock edge
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_fib("reset", 8'h8A, 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset.gal_data", 32'(gal_if.data), 32'h8A);

        @(negedge clk);
        reset = 1'b1;

        // Fibonacci default taps, three steps
        fib_if.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fib("fib_step", fib_exp[i], 8'(i + 1), 8'h00, 1'b0, 1'b0);
        end
        fib_if.en = 1'b0;

        // Galois taps 0x1D, three steps
        gal_if.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gal_step.data", 32'(gal_if.data), 32'(gal_exp[i]));
            check("gal_step.cnt",  32'(gal_if.step_cnt), 32'(i + 1));
        end
        gal_if.en = 1'b0;

        // Full period from SEED
        reset = 1'b0;
        #1;
        check("fullper.reset_data", 32'(fib_if.data), 32'h8A);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'h8A] = 1'b1;
        nwrap   = 0;
        nrepeat = 0;
        fib_if.en = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (fib_if.wrap) nwrap++;
            if (i < 255) begin
                if (seen[fib_if.data]) nrepeat++;
                seen[fib_if.data] = 1'b1;
            end
        end
        check_fib("fullper.end", 8'h8A, 8'h00, 8'hFF, 1'b0, 1'b1);
        check("fullper.nwrap", 32'(nwrap), 32'd1);
        check("fullper.nrepeat", 32'(nrepeat), 32'd0);
        fib_if.en = 1'b0;
        tick();
        check_fib("fullper.after", 8'h8A, 8'h00, 8'hFF, 1'b0, 1'b0);

        // Load zero, then lock-up recovery
        fib_if.load = 1'b1;
        fib_if.load_value = 8'h00;
        tick();
        check_fib("load0", 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
        fib_if.load = 1'b0;
        fib_if.en   = 1'b1;
        tick();
        check_fib("lockup", 8'h8A, 8'h00, 8'hFF, 1'b1, 1'b0);
        tick();
        check_fib("lockup.next", 8'h14, 8'h01, 8'hFF, 1'b0, 1'b0);

        // Load has priority over en
        fib_if.load = 1'b1;
        fib_if.load_value = 8'h55;
        tick();
        check_fib("load_prio", 8'h55, 8'h00, 8'hFF, 1'b0, 1'b0);
        fib_if.load = 1'b0;
        tick();
        check_fib("from55.1", 8'hAB, 8'h01, 8'hFF, 1'b0, 1'b0);
        tick();
        check_fib("from55.2", 8'h57, 8'h02, 8'hFF, 1'b0, 1'b0);

        // Hold with en=0
        fib_if.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_fib("hold", 8'h57, 8'h02, 8'hFF, 1'b0, 1'b0);
        end

        // Mid-run asynchronous reset
        fib_if.en = 1'b1;
        tick();
        check_fib("prereset", 8'hAF, 8'h03, 8'hFF, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_fib("midreset", 8'h8A, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_fib("postreset", 8'h14, 8'h01, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
